// File: rtl/bypass_select_gen_pkg.sv
// Shared bypass types: producer stage encoding, the registered select record
// and the lane-index width helper used by the bypass select generator.
package bypass_select_gen_pkg;

   // Where a consumer operand is taken from, as seen in the consumer's EX cycle
   typedef enum logic [1:0] {
      STG_INT_EX = 2'd0,
      STG_INT_WB = 2'd1,
      STG_MEM_MA = 2'd2,
      STG_MEM_WB = 2'd3
   } bypass_stg_e;

   // Widest lane index the select record can carry
   localparam int LANE_W_MAX = 8;

   typedef struct packed {
      logic                  valid;
      bypass_stg_e           stg;
      logic [LANE_W_MAX-1:0] lane;
   } bypass_sel_t;

   localparam bypass_sel_t SEL_NONE = '{valid: 1'b0, stg: STG_INT_EX, lane: '0};

   // Lane index width: clog2 of the larger producer count, at least one bit
   function automatic int lane_width(input int int_lanes, input int mem_lanes);
      int m;
      m = (int_lanes > mem_lanes) ? int_lanes : mem_lanes;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

   // Lane width for the default two-int / two-mem configuration
   localparam int LANE_W = lane_width(2, 2);

endpackage

// File: rtl/bypass_tag_stage.sv
// One bypass tag pipeline entry (valid + physical tag). Reset clears both
// fields, flush drops the valid, stall holds, otherwise the entry loads.
module bypass_tag_stage
   import bypass_select_gen_pkg::*;
#(
   parameter int PREG_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [PREG_W-1:0] in_tag,
   output logic              valid,
   output logic [PREG_W-1:0] tag
);

   // Tag entry update: rst > clear > stall > load
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         tag   <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (!stall) begin
         valid <= in_valid;
         tag   <= in_tag;
      end
   end

endmodule

// File: rtl/bypass_select_gen.sv
// Bypass select generator. Consumer source tags in RR are compared against
// producers in RR (forwarded from INT_EX / MEM_MA next cycle) and, when
// BYPASS_SELECT_WB_STAGE_EN is defined, against producers one stage older
// (forwarded from INT_WB / MEM_WB). Selects are registered so they line up
// with the consumer's EX cycle.
module bypass_select_gen
   import bypass_select_gen_pkg::*;
#(
   parameter int INT_LANES = 2,
   parameter int MEM_LANES = 2,
   parameter int SRC_PORTS = 8,
   parameter int PREG_W    = 7,
   localparam int LANE_BITS = lane_width(INT_LANES, MEM_LANES)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic                          clear,
   input  logic [INT_LANES-1:0]          intDstValid,
   input  logic [INT_LANES*PREG_W-1:0]   intDstTag,
   input  logic [MEM_LANES-1:0]          memDstValid,
   input  logic [MEM_LANES*PREG_W-1:0]   memDstTag,
   input  logic [SRC_PORTS-1:0]          srcValid,
   input  logic [SRC_PORTS*PREG_W-1:0]   srcTag,
   output logic [SRC_PORTS-1:0]          selValid,
   output logic [SRC_PORTS*2-1:0]        selStg,
   output logic [SRC_PORTS*LANE_BITS-1:0] selLane
);

   bypass_sel_t sel_next [SRC_PORTS];
   bypass_sel_t sel_reg  [SRC_PORTS];

`ifdef BYPASS_SELECT_WB_STAGE_EN
   // The EX/MA tag entries exist only to feed the WB-stage matches; without
   // that feature an older producer is always read from the register file.
   logic [INT_LANES-1:0] int_ex_valid;
   logic [PREG_W-1:0]    int_ex_tag [INT_LANES];
   logic [MEM_LANES-1:0] mem_ma_valid;
   logic [PREG_W-1:0]    mem_ma_tag [MEM_LANES];
   logic [INT_LANES-1:0] int_wb_valid;
   logic [PREG_W-1:0]    int_wb_tag [INT_LANES];
   logic [MEM_LANES-1:0] mem_wb_valid;
   logic [PREG_W-1:0]    mem_wb_tag [MEM_LANES];

   for (genvar gi = 0; gi < INT_LANES; gi++) begin : g_int_tags
      bypass_tag_stage #(.PREG_W(PREG_W)) u_ex (
         .clk     (clk),
         .rst     (rst),
         .stall   (stall),
         .clear   (clear),
         .in_valid(intDstValid[gi]),
         .in_tag  (intDstTag[gi*PREG_W +: PREG_W]),
         .valid   (int_ex_valid[gi]),
         .tag     (int_ex_tag[gi])
      );
      bypass_tag_stage #(.PREG_W(PREG_W)) u_wb (
         .clk     (clk),
         .rst     (rst),
         .stall   (stall),
         .clear   (clear),
         .in_valid(int_ex_valid[gi]),
         .in_tag  (int_ex_tag[gi]),
         .valid   (int_wb_valid[gi]),
         .tag     (int_wb_tag[gi])
      );
   end

   for (genvar gi = 0; gi < MEM_LANES; gi++) begin : g_mem_tags
      bypass_tag_stage #(.PREG_W(PREG_W)) u_ma (
         .clk     (clk),
         .rst     (rst),
         .stall   (stall),
         .clear   (clear),
         .in_valid(memDstValid[gi]),
         .in_tag  (memDstTag[gi*PREG_W +: PREG_W]),
         .valid   (mem_ma_valid[gi]),
         .tag     (mem_ma_tag[gi])
      );
      bypass_tag_stage #(.PREG_W(PREG_W)) u_wb (
         .clk     (clk),
         .rst     (rst),
         .stall   (stall),
         .clear   (clear),
         .in_valid(mem_ma_valid[gi]),
         .in_tag  (mem_ma_tag[gi]),
         .valid   (mem_wb_valid[gi]),
         .tag     (mem_wb_tag[gi])
      );
   end
`endif

   // Select search: candidates are scanned lowest priority first and highest
   // lane first, so the last hit is the winner (INT_EX > MEM_MA > INT_WB >
   // MEM_WB, then lowest lane).
   always_comb begin
      for (int p = 0; p < SRC_PORTS; p++) begin
         sel_next[p] = SEL_NONE;
         if (srcValid[p]) begin
`ifdef BYPASS_SELECT_WB_STAGE_EN
            for (int l = MEM_LANES - 1; l >= 0; l--) begin
               if (mem_ma_valid[l] && (mem_ma_tag[l] == srcTag[p*PREG_W +: PREG_W])) begin
                  sel_next[p] = '{valid: 1'b1, stg: STG_MEM_WB, lane: LANE_W_MAX'(l)};
               end
            end
            for (int l = INT_LANES - 1; l >= 0; l--) begin
               if (int_ex_valid[l] && (int_ex_tag[l] == srcTag[p*PREG_W +: PREG_W])) begin
                  sel_next[p] = '{valid: 1'b1, stg: STG_INT_WB, lane: LANE_W_MAX'(l)};
               end
            end
`endif
            for (int l = MEM_LANES - 1; l >= 0; l--) begin
               if (memDstValid[l] &&
                   (memDstTag[l*PREG_W +: PREG_W] == srcTag[p*PREG_W +: PREG_W])) begin
                  sel_next[p] = '{valid: 1'b1, stg: STG_MEM_MA, lane: LANE_W_MAX'(l)};
               end
            end
            for (int l = INT_LANES - 1; l >= 0; l--) begin
               if (intDstValid[l] &&
                   (intDstTag[l*PREG_W +: PREG_W] == srcTag[p*PREG_W +: PREG_W])) begin
                  sel_next[p] = '{valid: 1'b1, stg: STG_INT_EX, lane: LANE_W_MAX'(l)};
               end
            end
         end
      end
   end

   // Select registers: rst and flush zero them, stall holds, else capture
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int p = 0; p < SRC_PORTS; p++) begin
            sel_reg[p] <= SEL_NONE;
         end
      end else if (!stall) begin
         for (int p = 0; p < SRC_PORTS; p++) begin
            sel_reg[p] <= sel_next[p];
         end
      end
   end

   for (genvar gi = 0; gi < SRC_PORTS; gi++) begin : g_out
      assign selValid[gi]                        = sel_reg[gi].valid;
      assign selStg[gi*2 +: 2]                   = sel_reg[gi].stg;
      assign selLane[gi*LANE_BITS +: LANE_BITS]  = sel_reg[gi].lane[LANE_BITS-1:0];
   end

endmodule

// File: tb/tb_bypass_select_gen.sv
// Self-checking bench for bypass_select_gen: directed scenarios followed by
// random traffic, all compared against a producer-history reference model.
module tb_bypass_select_gen;

   localparam int INT_LANES = 2;
   localparam int MEM_LANES = 2;
   localparam int SRC_PORTS = 8;
   localparam int PREG_W    = 7;
   localparam int LANE_W    = 1;
`ifdef BYPASS_SELECT_WB_STAGE_EN
   localparam bit WB_EN = 1'b1;
`else
   localparam bit WB_EN = 1'b0;
`endif

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          stall;
   logic                          clear;
   logic [INT_LANES-1:0]          intDstValid;
   logic [INT_LANES*PREG_W-1:0]   intDstTag;
   logic [MEM_LANES-1:0]          memDstValid;
   logic [MEM_LANES*PREG_W-1:0]   memDstTag;
   logic [SRC_PORTS-1:0]          srcValid;
   logic [SRC_PORTS*PREG_W-1:0]   srcTag;
   logic [SRC_PORTS-1:0]          selValid;
   logic [SRC_PORTS*2-1:0]        selStg;
   logic [SRC_PORTS*LANE_W-1:0]   selLane;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   // Model: producers issued in the previous accepted cycle, plus expected selects
   bit                hist_int_v [INT_LANES];
   logic [PREG_W-1:0] hist_int_t [INT_LANES];
   bit                hist_mem_v [MEM_LANES];
   logic [PREG_W-1:0] hist_mem_t [MEM_LANES];
   int                exp_v [SRC_PORTS];
   int                exp_s [SRC_PORTS];
   int                exp_l [SRC_PORTS];

   bypass_select_gen #(
      .INT_LANES(INT_LANES),
      .MEM_LANES(MEM_LANES),
      .SRC_PORTS(SRC_PORTS),
      .PREG_W   (PREG_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .clear      (clear),
      .intDstValid(intDstValid),
      .intDstTag  (intDstTag),
      .memDstValid(memDstValid),
      .memDstTag  (memDstTag),
      .srcValid   (srcValid),
      .srcTag     (srcTag),
      .selValid   (selValid),
      .selStg     (selStg),
      .selLane    (selLane)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cycle, got, exp);
      end
   endtask

   // Expected source of one operand, by stage priority then lowest lane
   function automatic void pick(input int p, output int v, output int s, output int l);
      logic [PREG_W-1:0] t;
      t = srcTag[p*PREG_W +: PREG_W];
      v = 0; s = 0; l = 0;
      if (!srcValid[p]) return;
      for (int i = 0; i < INT_LANES; i++)
         if (intDstValid[i] && intDstTag[i*PREG_W +: PREG_W] == t) begin v = 1; s = 0; l = i; return; end
      for (int i = 0; i < MEM_LANES; i++)
         if (memDstValid[i] && memDstTag[i*PREG_W +: PREG_W] == t) begin v = 1; s = 2; l = i; return; end
      if (!WB_EN) return;
      for (int i = 0; i < INT_LANES; i++)
         if (hist_int_v[i] && hist_int_t[i] == t) begin v = 1; s = 1; l = i; return; end
      for (int i = 0; i < MEM_LANES; i++)
         if (hist_mem_v[i] && hist_mem_t[i] == t) begin v = 1; s = 3; l = i; return; end
   endfunction

   // One clock: predict, advance, then compare every port
   task automatic step();
      int nv [SRC_PORTS];
      int ns [SRC_PORTS];
      int nl [SRC_PORTS];
      for (int p = 0; p < SRC_PORTS; p++) pick(p, nv[p], ns[p], nl[p]);
      @(posedge clk);
      #1;
      cycle++;
      if (rst || clear) begin
         for (int p = 0; p < SRC_PORTS; p++) begin exp_v[p] = 0; exp_s[p] = 0; exp_l[p] = 0; end
         for (int i = 0; i < INT_LANES; i++) hist_int_v[i] = 0;
         for (int i = 0; i < MEM_LANES; i++) hist_mem_v[i] = 0;
      end else if (!stall) begin
         for (int p = 0; p < SRC_PORTS; p++) begin exp_v[p] = nv[p]; exp_s[p] = ns[p]; exp_l[p] = nl[p]; end
         for (int i = 0; i < INT_LANES; i++) begin
            hist_int_v[i] = intDstValid[i];
            hist_int_t[i] = intDstTag[i*PREG_W +: PREG_W];
         end
         for (int i = 0; i < MEM_LANES; i++) begin
            hist_mem_v[i] = memDstValid[i];
            hist_mem_t[i] = memDstTag[i*PREG_W +: PREG_W];
         end
      end
      for (int p = 0; p < SRC_PORTS; p++) begin
         check_eq($sformatf("selValid[%0d]", p), int'(selValid[p]), exp_v[p]);
         check_eq($sformatf("selStg[%0d]", p), int'(selStg[p*2 +: 2]), exp_s[p]);
         check_eq($sformatf("selLane[%0d]", p), int'(selLane[p*LANE_W +: LANE_W]), exp_l[p]);
      end
      $display("cyc %0d rst=%0b clr=%0b stall=%0b selValid=%b selStg=%h selLane=%b",
               cycle, rst, clear, stall, selValid, selStg, selLane);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; stall = 1'b0; clear = 1'b0;
      intDstValid = '0; intDstTag = '0;
      memDstValid = '0; memDstTag = '0;
      srcValid = '0; srcTag = '0;
   endtask

   task automatic set_int(input int lane, input int tag);
      intDstValid[lane] = 1'b1;
      intDstTag[lane*PREG_W +: PREG_W] = PREG_W'(tag);
   endtask

   task automatic set_mem(input int lane, input int tag);
      memDstValid[lane] = 1'b1;
      memDstTag[lane*PREG_W +: PREG_W] = PREG_W'(tag);
   endtask

   task automatic set_src(input int p, input int tag);
      srcValid[p] = 1'b1;
      srcTag[p*PREG_W +: PREG_W] = PREG_W'(tag);
   endtask

   initial begin
      for (int i = 0; i < INT_LANES; i++) begin hist_int_v[i] = 0; hist_int_t[i] = '0; end
      for (int i = 0; i < MEM_LANES; i++) begin hist_mem_v[i] = 0; hist_mem_t[i] = '0; end
      for (int p = 0; p < SRC_PORTS; p++) begin exp_v[p] = 0; exp_s[p] = 0; exp_l[p] = 0; end
      idle_inputs();

      // Reset state
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // RR int lane1 producer feeds a same-cycle consumer from INT_EX
      set_int(1, 'h12); set_src(0, 'h12);
      step();
      check_eq("ex_hit_valid", int'(selValid[0]), 1);
      check_eq("ex_hit_lane", int'(selLane[0]), 1);

      // Consumer one cycle behind the producer: INT_WB when enabled
      idle_inputs();
      set_src(0, 'h12);
      step();
      check_eq("wb_hit_valid", int'(selValid[0]), WB_EN ? 1 : 0);
      check_eq("wb_hit_stg", int'(selStg[1:0]), WB_EN ? 1 : 0);

      // Int and mem lane0 both produce 0x20: INT_EX wins
      idle_inputs();
      set_int(0, 'h20); set_mem(0, 'h20); set_src(3, 'h20);
      step();
      check_eq("prio_stg", int'(selStg[7:6]), 0);

      // Match, then stall three cycles with new inputs, then release
      idle_inputs();
      set_int(1, 'h12); set_src(0, 'h12);
      step();
      idle_inputs();
      stall = 1'b1;
      set_int(0, 'h33); set_src(0, 'h33); set_src(1, 'h12);
      repeat (3) step();
      check_eq("stall_hold_valid", int'(selValid[0]), 1);
      idle_inputs();
      set_src(0, 'h12);
      step();

      // Flush together with stall, with 0x12 sitting in EX
      idle_inputs();
      set_int(1, 'h12);
      step();
      idle_inputs();
      clear = 1'b1; stall = 1'b1; set_src(0, 'h12);
      step();
      check_eq("clear_valid", int'(selValid), 0);
      idle_inputs();
      set_src(0, 'h12);
      step();
      check_eq("clear_no_wb", int'(selValid[0]), 0);

      // Reset in mid-stream
      idle_inputs();
      set_int(1, 'h12); set_src(2, 'h12);
      step();
      idle_inputs();
      rst = 1'b1; set_int(0, 'h12); set_src(0, 'h12);
      step();
      check_eq("rst_valid", int'(selValid), 0);
      idle_inputs();
      set_src(0, 'h12);
      step();

      // Operand not read: no bypass even on a tag hit
      idle_inputs();
      set_int(0, 'h05);
      srcTag[0 +: PREG_W] = PREG_W'(7'h05);
      step();
      check_eq("src_invalid", int'(selValid[0]), 0);

      // Random traffic over a small tag space to force frequent hits
      for (int n = 0; n < 400; n++) begin
         idle_inputs();
         rst   = ($urandom_range(0, 99) < 2);
         clear = ($urandom_range(0, 99) < 4);
         stall = ($urandom_range(0, 99) < 15);
         for (int i = 0; i < INT_LANES; i++) begin
            intDstValid[i] = 1'($urandom_range(0, 1));
            intDstTag[i*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 7));
         end
         for (int i = 0; i < MEM_LANES; i++) begin
            memDstValid[i] = 1'($urandom_range(0, 1));
            memDstTag[i*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 7));
         end
         for (int p = 0; p < SRC_PORTS; p++) begin
            srcValid[p] = ($urandom_range(0, 3) != 0);
            srcTag[p*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 7));
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
